bin_to_bcd_seq: RTL

Sequential binary-to-packed-BCD converter that feeds the 4-digit seven-segment display driver's 16-bit `in` bus.
- Accepts a 14-bit binary value on a start pulse.
- Converts it with iterative shift-add-3 (double dabble), one bit per clock.
- Presents a held 4-digit BCD result. The display always shows decimal and never shows a half-converted value.

---
 rtl/bin_to_bcd_seq_pkg.sv | 13 +
 rtl/bin_to_bcd_seq_if.sv | 15 +
 rtl/bcd_digit_adj.sv | 10 +
 rtl/bin_to_bcd_seq.sv | 83 ++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam int unsigned MAX_DEC = 9999;
  localparam logic [15:0] SAT_BCD = 16'h9999;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a requester and the BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int unsigned IN_W   = 14,
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic [IN_W-1:0]       bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (output start, bin, input busy, done, bcd, ovf);
  modport slave  (input start, bin, output busy, done, bcd, ovf);
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter, one input bit per clock; result held until the next DONE.
module bin_to_bcd_seq #(
  parameter int unsigned IN_W    = 14,
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned MAX_DEC = bin_to_bcd_seq_pkg::MAX_DEC
) (
  input logic               clk,
  input logic               reset,
  bin_to_bcd_seq_if.slave   bus
);
  import bin_to_bcd_seq_pkg::*;

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(IN_W + 1);
  localparam logic [IN_W-1:0] MaxDecW = IN_W'(MAX_DEC);
  localparam logic [BcdW-1:0] SatVal  = (DIGITS == 4) ? BcdW'(SAT_BCD) : {DIGITS{4'h9}};

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [IN_W-1:0]   bin_work_q;
  logic [BcdW-1:0]   bcd_work_q;
  logic [BcdW-1:0]   bcd_adj;
  logic              sat_q;
  logic [BcdW-1:0]   bcd_q;
  logic              ovf_q;
  logic              busy_q;
  logic              done_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (bcd_work_q[4*g +: 4]),
      .q (bcd_adj[4*g +: 4])
    );
  end

  // Outputs are registered, so busy/done trail the state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bin_work_q <= '0;
      bcd_work_q <= '0;
      sat_q      <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            bin_work_q <= bus.bin;
            bcd_work_q <= '0;
            cnt_q      <= CntW'(IN_W);
            sat_q      <= (bus.bin > MaxDecW);
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          busy_q                   <= 1'b1;
          {bcd_work_q, bin_work_q} <= {bcd_adj, bin_work_q} << 1;
          cnt_q                    <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_q <= S_DONE;
        end
        S_DONE: begin
          bcd_q   <= sat_q ? SatVal : bcd_work_q;
          ovf_q   <= sat_q;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;

endmodule
